saradc_sar_ctrl: RTL and testbench
==================================

Name: saradc_sar_ctrl

Overview:
Successive-approximation control FSM for the SAR ADC macro. It sequences the input sampling switch (ASSW inverter cell), drives the bottom-plate control bits of the binary-weighted capacitor DAC (ASCAP inverter cells), and strobes the comparator. It resolves one bit per trial MSB-first and presents the conversion result to the digital core. It sits directly upstream of the analog switch/cap-driver cells.

Parameters:
NBITS, 8, resolution and DAC control width; legal range 2..16
SAMPLE_CYCLES, 2, clock cycles the sample switch stays closed; >=1
SETTLE_CYCLES, 1, DAC settling cycles before each comparison; >=0

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a conversion; sampled only in IDLE or DONE
abort  input  1  synchronous abort; returns to IDLE without done
cmp_out  input  1  comparator decision; 1 = input above the current DAC trial
sample  output  1  sampling switch enable, active-high
dac_p  output  NBITS  cap-DAC bottom-plate control, bit k drives weight 2^k
cmp_en  output  1  comparator strobe
busy  output  1  high from SAMPLE entry until DONE exit
done  output  1  one-cycle pulse: dout updated
dout  output  NBITS  last completed conversion result

Behaviour:
- All outputs are registered. Reset values: sample=0, dac_p=0, cmp_en=0, busy=0, done=0, dout=0, state=IDLE, counters=0.
- States: IDLE, SAMPLE, SETTLE, COMPARE, DONE.
- IDLE: all control outputs 0. start=1 -> SAMPLE; sample=1, busy=1, dac_p=0, sample counter loaded.
- SAMPLE: held exactly SAMPLE_CYCLES cycles. On exit: sample=0, dac_p = 1<<(NBITS-1), bit index = NBITS-1. Go to SETTLE, or to COMPARE if SETTLE_CYCLES=0.
- SETTLE: held SETTLE_CYCLES cycles with dac_p stable. Then COMPARE.
- COMPARE: one cycle with cmp_en=1. cmp_out is captured on the edge that ends the cycle. cmp_out=0 clears the trial bit; cmp_out=1 keeps it.
  - If the index is >0: set the next lower bit, decrement the index, go to SETTLE (or COMPARE when SETTLE_CYCLES=0).
  - If the index is 0: dout <= final dac_p value, done=1, go to DONE.
- cmp_out is ignored outside COMPARE.
- DONE: one cycle. done=1, busy=1, dac_p holds the result.
  - start=1 in DONE -> SAMPLE directly (back-to-back, no idle gap).
  - Otherwise -> IDLE, with dac_p cleared and busy=0.
- Latency: with start sampled at edge E0, done is high in the cycle following edge E(SAMPLE_CYCLES + NBITS*(SETTLE_CYCLES+1)). For the defaults that is E18.
- start while busy (SAMPLE/SETTLE/COMPARE) is ignored and not queued.
- abort=1 in any state:
  - next state IDLE; sample, dac_p, cmp_en, busy cleared; done not asserted; dout unchanged.
  - abort has priority over start in the same cycle.
- rst mid-conversion: everything returns to reset values, including dout=0. rst has priority over abort and start.
- sample and cmp_en are never high in the same cycle. dac_p is 0 whenever sample=1.
- dac_p changes only on COMPARE-exit or SAMPLE-exit edges, so it is stable for the full SETTLE window.

Test Plan:
- Behavioural comparator model cmp_out = (vin_code >= dac_p), defaults, vin_code=0xA5, start pulsed at E0:
  - sample high E0..E2;
  - trial sequence 0x80, 0xC0 (clear), 0xA0, 0xB0 (clear), 0xA8 (clear), 0xA4, 0xA6 (clear), 0xA5;
  - done high one cycle after E18, dout=0xA5.
- Extremes: vin_code=0x00 -> dout=0x00; vin_code=0xFF -> dout=0xFF. Each has exactly 8 cmp_en pulses per conversion.
- start held high continuously with vin_code 0x3C then 0xC3:
  - DONE goes directly to SAMPLE;
  - consecutive done pulses 19 cycles apart;
  - dout=0x3C then 0xC3.
- abort asserted on the 3rd cmp_en pulse, after a prior result dout=0x5A:
  - next cycle IDLE, dac_p=0, busy=0;
  - no done pulse; dout stays 0x5A.
- rst asserted mid-SETTLE with start also high: all outputs 0 the next cycle, dout=0x00, and the FSM stays in IDLE while rst is high.
- SETTLE_CYCLES=0, SAMPLE_CYCLES=1, NBITS=4, vin_code=0x9:
  - cmp_en high every cycle for 4 cycles;
  - done one cycle after E5; dout=0x9.

Source files
------------

// File: rtl/saradc_sar_ctrl_if.sv
// rtl/saradc_sar_ctrl_if.sv - SAR controller bundle between digital core, analog cells and controller
//
// Groups the conversion handshake (start/abort/busy/done/dout) with the
// analog-facing controls (sample/dac_p/cmp_en) and the comparator decision.
//   master : the environment (digital core + analog macro model) driving start, abort, cmp_out
//   slave  : the SAR controller driving sample, dac_p, cmp_en, busy, done, dout
interface saradc_sar_ctrl_if #(
  parameter int NBITS = 8
);
  logic             start;
  logic             abort;
  logic             cmp_out;
  logic             sample;
  logic [NBITS-1:0] dac_p;
  logic             cmp_en;
  logic             busy;
  logic             done;
  logic [NBITS-1:0] dout;

  modport master (
    output start, abort, cmp_out,
    input  sample, dac_p, cmp_en, busy, done, dout
  );

  modport slave (
    input  start, abort, cmp_out,
    output sample, dac_p, cmp_en, busy, done, dout
  );
endinterface

// File: rtl/saradc_sar_ctrl.sv
// rtl/saradc_sar_ctrl.sv - successive-approximation control FSM for the SAR ADC macro
//
// Sequences the sampling switch, the binary-weighted cap-DAC bottom plates and
// the comparator strobe, resolving one bit per trial MSB-first.
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset (priority over abort and start)
//   bus.start    conversion request, honoured only in IDLE or DONE
//   bus.abort    return to IDLE without done, dout kept
//   bus.cmp_out  comparator decision, 1 = input above current DAC trial
//   bus.sample   sampling switch enable
//   bus.dac_p    cap-DAC bottom-plate control, bit k drives weight 2^k
//   bus.cmp_en   comparator strobe (one cycle per trial)
//   bus.busy     high from SAMPLE entry until DONE exit
//   bus.done     one-cycle pulse when dout is updated
//   bus.dout     last completed conversion result
// All outputs are registered.
module saradc_sar_ctrl #(
  parameter int NBITS         = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input logic              clk,
  input logic              rst,
  saradc_sar_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SAMPLE  = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_COMPARE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // One shared down-counter serves both SAMPLE and SETTLE windows.
  localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW   = (CMAX <= 2) ? 1 : $clog2(CMAX);
  localparam int IW   = $clog2(NBITS);

  localparam logic [CW-1:0]    SAMPLE_LOAD = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0]    SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;
  localparam logic [IW-1:0]    IDX_TOP     = IW'(NBITS - 1);
  localparam logic [NBITS-1:0] MSB_TRIAL   = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [NBITS-1:0] ONE         = {{(NBITS-1){1'b0}}, 1'b1};

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic             sample_r;
  logic [NBITS-1:0] dac_r;
  logic             cmp_en_r;
  logic             busy_r;
  logic             done_r;
  logic [NBITS-1:0] dout_r;

  // resolved: current trial with the bit under test replaced by the decision.
  // next_trial: resolved value plus the next lower trial bit.
  logic [NBITS-1:0] resolved;
  logic [NBITS-1:0] next_trial;

  always_comb begin
    resolved      = dac_r;
    resolved[idx] = bus.cmp_out;
    next_trial    = resolved | (ONE << (idx - 1'b1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx      <= '0;
      sample_r <= 1'b0;
      dac_r    <= '0;
      cmp_en_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dout_r   <= '0;
    end else if (bus.abort) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx      <= '0;
      sample_r <= 1'b0;
      dac_r    <= '0;
      cmp_en_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state    <= ST_SAMPLE;
            sample_r <= 1'b1;
            busy_r   <= 1'b1;
            dac_r    <= '0;
            cnt      <= SAMPLE_LOAD;
          end
        end

        ST_SAMPLE: begin
          if (cnt == '0) begin
            sample_r <= 1'b0;
            dac_r    <= MSB_TRIAL;
            idx      <= IDX_TOP;
            if (SETTLE_CYCLES == 0) begin
              state    <= ST_COMPARE;
              cmp_en_r <= 1'b1;
            end else begin
              state <= ST_SETTLE;
              cnt   <= SETTLE_LOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_SETTLE: begin
          if (cnt == '0) begin
            state    <= ST_COMPARE;
            cmp_en_r <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_COMPARE: begin
          if (idx != '0) begin
            dac_r <= next_trial;
            idx   <= idx - 1'b1;
            // With no settle window the strobe stays up for the next trial.
            if (SETTLE_CYCLES == 0) begin
              cmp_en_r <= 1'b1;
            end else begin
              state    <= ST_SETTLE;
              cnt      <= SETTLE_LOAD;
              cmp_en_r <= 1'b0;
            end
          end else begin
            dac_r    <= resolved;
            dout_r   <= resolved;
            done_r   <= 1'b1;
            cmp_en_r <= 1'b0;
            state    <= ST_DONE;
          end
        end

        ST_DONE: begin
          done_r <= 1'b0;
          dac_r  <= '0;
          if (bus.start) begin
            // Back-to-back conversion: no idle gap.
            state    <= ST_SAMPLE;
            sample_r <= 1'b1;
            busy_r   <= 1'b1;
            cnt      <= SAMPLE_LOAD;
          end else begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
          end
        end

        default: begin
          state    <= ST_IDLE;
          sample_r <= 1'b0;
          dac_r    <= '0;
          cmp_en_r <= 1'b0;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sample = sample_r;
  assign bus.dac_p  = dac_r;
  assign bus.cmp_en = cmp_en_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.dout   = dout_r;

endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// tb/tb_saradc_sar_ctrl.sv - scoreboard bench for saradc_sar_ctrl (default and 4-bit/no-settle configs)
module tb_saradc_sar_ctrl;

  localparam int NB0 = 8, SA0 = 2, SE0 = 1;
  localparam int NB1 = 4, SA1 = 1, SE1 = 0;
  localparam int LAT0 = SA0 + NB0 * (SE0 + 1);
  localparam int LAT1 = SA1 + NB1 * (SE1 + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  saradc_sar_ctrl_if #(.NBITS(NB0)) bus0 ();
  saradc_sar_ctrl_if #(.NBITS(NB1)) bus1 ();

  logic [7:0] vin0;
  logic [3:0] vin1;

  // Ideal comparator: input code at or above the DAC trial reads as 1.
  assign bus0.cmp_out = (vin0 >= bus0.dac_p);
  assign bus1.cmp_out = (vin1 >= bus1.dac_p);

  saradc_sar_ctrl #(.NBITS(NB0), .SAMPLE_CYCLES(SA0), .SETTLE_CYCLES(SE0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  saradc_sar_ctrl #(.NBITS(NB1), .SAMPLE_CYCLES(SA1), .SETTLE_CYCLES(SE1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  logic [1:0]  m_sample, m_cmp_en, m_busy, m_done;
  logic [15:0] m_dac [2];
  logic [15:0] m_dout [2];
  assign m_sample = {bus1.sample, bus0.sample};
  assign m_cmp_en = {bus1.cmp_en, bus0.cmp_en};
  assign m_busy   = {bus1.busy, bus0.busy};
  assign m_done   = {bus1.done, bus0.done};
  assign m_dac[0]  = 16'(bus0.dac_p);
  assign m_dac[1]  = 16'(bus1.dac_p);
  assign m_dout[0] = 16'(bus0.dout);
  assign m_dout[1] = 16'(bus1.dout);

  typedef struct {
    int dout;
    int cyc;
  } exp_t;

  int   exp_trial [2][$];
  exp_t exp_done [2][$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int nb_of(input int d);
    return (d == 0) ? NB0 : NB1;
  endfunction

  function automatic int sa_of(input int d);
    return (d == 0) ? SA0 : SA1;
  endfunction

  // Reference: binary search over the code space, MSB first.
  task automatic push_conv(input int d, input int vin, input int done_cyc, input bit with_done);
    int   code = 0;
    int   trial;
    exp_t e;
    for (int k = nb_of(d) - 1; k >= 0; k--) begin
      trial = code | (1 << k);
      exp_trial[d].push_back(trial);
      if (vin >= trial) code = trial;
    end
    if (with_done) begin
      e.dout = code;
      e.cyc  = done_cyc;
      exp_done[d].push_back(e);
    end
  endtask

  // Monitor / scoreboard
  int   srun [2];
  int   pulses [2];
  exp_t mon_e;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        srun[d]   = 0;
        pulses[d] = 0;
      end else begin
        if (m_sample[d]) begin
          if (srun[d] == 0) pulses[d] = 0;
          srun[d]++;
          check($sformatf("sample_vs_cmp_en%0d", d), int'(m_cmp_en[d]), 0);
          check($sformatf("dac_zero_in_sample%0d", d), int'(m_dac[d]), 0);
        end else if (srun[d] > 0) begin
          check($sformatf("sample_len%0d", d), srun[d], sa_of(d));
          srun[d] = 0;
        end
        if (m_cmp_en[d]) begin
          pulses[d]++;
          if (exp_trial[d].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_cmp_en%0d actual=1 required=0 (cycle %0d)", d, cyc);
          end else begin
            check($sformatf("trial%0d", d), int'(m_dac[d]), exp_trial[d].pop_front());
          end
        end
        if (m_done[d]) begin
          if (exp_done[d].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done%0d actual=1 required=0 (cycle %0d)", d, cyc);
          end else begin
            mon_e = exp_done[d].pop_front();
            check($sformatf("dout%0d", d), int'(m_dout[d]), mon_e.dout);
            check($sformatf("done_cycle%0d", d), cyc, mon_e.cyc);
            check($sformatf("cmp_pulses%0d", d), pulses[d], nb_of(d));
            check($sformatf("dac_in_done%0d", d), int'(m_dac[d]), mon_e.dout);
            check($sformatf("busy_in_done%0d", d), int'(m_busy[d]), 1);
          end
        end
      end
    end
  end

  task automatic set_start(input int d, input logic v);
    if (d == 0) bus0.start = v;
    else        bus1.start = v;
  endtask

  task automatic set_vin(input int d, input int v);
    if (d == 0) vin0 = 8'(v);
    else        vin1 = 4'(v);
  endtask

  // One conversion from a negedge; optionally pokes start while busy.
  task automatic conv(input int d, input int vin, input bit poke);
    int lat;
    int k;
    lat = (d == 0) ? LAT0 : LAT1;
    set_vin(d, vin);
    set_start(d, 1'b1);
    push_conv(d, vin, cyc + 1 + lat, 1'b1);
    k = poke ? int'($urandom_range(1, lat - 1)) : 0;
    for (int i = 1; i <= lat + 1; i++) begin
      @(negedge clk);
      set_start(d, 1'(i == k));
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int t;
    int v;
    rst = 1'b1;
    bus0.start = 1'b0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    vin0 = '0; vin1 = '0;
    repeat (3) @(negedge clk);
    check("rst_ctl0", int'({bus0.sample, bus0.cmp_en, bus0.busy, bus0.done}), 0);
    check("rst_dac0", int'(bus0.dac_p), 0);
    check("rst_dout0", int'(bus0.dout), 0);
    check("rst_ctl1", int'({bus1.sample, bus1.cmp_en, bus1.busy, bus1.done}), 0);
    check("rst_dac1", int'(bus1.dac_p), 0);
    rst = 1'b0;
    @(negedge clk);

    conv(0, 'hA5, 1'b0);
    conv(0, 'h00, 1'b0);
    conv(0, 'hFF, 1'b0);
    for (int i = 0; i < 6; i++) conv(0, int'($urandom_range(0, 255)), 1'b1);

    // Start held high: DONE goes straight back to SAMPLE.
    vin0 = 8'h3C;
    bus0.start = 1'b1;
    push_conv(0, 'h3C, cyc + 1 + LAT0, 1'b1);
    push_conv(0, 'hC3, cyc + 1 + LAT0 + LAT0 + 1, 1'b1);
    repeat (LAT0 + 1) @(negedge clk);
    vin0 = 8'hC3;
    repeat (LAT0 + 1) @(negedge clk);
    bus0.start = 1'b0;
    @(negedge clk);

    // Abort on the 3rd strobe after a completed 0x5A conversion.
    conv(0, 'h5A, 1'b0);
    v = int'($urandom_range(0, 255));
    vin0 = 8'(v);
    bus0.start = 1'b1;
    push_conv(0, v, 0, 1'b0);
    n = 0;
    t = 0;
    while (n < 3 && t < 40) begin
      @(negedge clk);
      bus0.start = 1'b0;
      t++;
      if (bus0.cmp_en) n++;
    end
    if (n < 3) begin
      checks++;
      failures++;
      $display("FAIL abort_wait actual=%0d required=3 strobes", n);
    end
    bus0.abort = 1'b1;
    @(negedge clk);
    bus0.abort = 1'b0;
    check("abort_busy", int'(bus0.busy), 0);
    check("abort_dac", int'(bus0.dac_p), 0);
    check("abort_ctl", int'({bus0.sample, bus0.cmp_en, bus0.done}), 0);
    check("abort_dout", int'(bus0.dout), 'h5A);
    exp_trial[0].delete();
    repeat (LAT0 + 4) @(negedge clk);
    check("abort_dout_later", int'(bus0.dout), 'h5A);

    // Reset during SETTLE with start held.
    vin0 = 8'($urandom_range(0, 255));
    bus0.start = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_settle_dac", int'(bus0.dac_p), 'h80);
    check("pre_rst_settle_ctl", int'({bus0.sample, bus0.cmp_en, bus0.busy}), 1);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_ctl", int'({bus0.sample, bus0.cmp_en, bus0.busy, bus0.done}), 0);
      check("rst_mid_dac", int'(bus0.dac_p), 0);
      check("rst_mid_dout", int'(bus0.dout), 0);
    end
    exp_trial[0].delete();
    rst = 1'b0;
    bus0.start = 1'b0;
    @(negedge clk);
    check("post_rst_idle", int'(bus0.busy), 0);

    // 4-bit, single sample cycle, no settle window.
    conv(1, 'h9, 1'b0);
    conv(1, 'h0, 1'b0);
    conv(1, 'hF, 1'b0);
    for (int i = 0; i < 3; i++) conv(1, int'($urandom_range(0, 15)), 1'b1);

    conv(0, int'($urandom_range(0, 255)), 1'b0);

    repeat (4) @(negedge clk);
    check("trial_q_empty0", exp_trial[0].size(), 0);
    check("done_q_empty0", exp_done[0].size(), 0);
    check("trial_q_empty1", exp_trial[1].size(), 0);
    check("done_q_empty1", exp_done[1].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
